// File: rtl/bpred_dual_mem.sv
// Branch-predictor front-end storage: a 256x32 instruction RAM and a 256x36 byte-lane predictor RAM.
// Both are simple-dual-port, read-first, with a registered (1-cycle) read port.
module bpred_dual_mem #(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned IM_DW    = 32,
    parameter int unsigned PM_DW    = 36,
    parameter int unsigned PM_LANES = 4
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                im_wren,
    input  logic [ADDR_W-1:0]   im_wraddr,
    input  logic [IM_DW-1:0]    im_wdata,
    input  logic [ADDR_W-1:0]   im_rdaddr,
    output logic [IM_DW-1:0]    im_q,

    input  logic                pm_wren,
    input  logic [PM_LANES-1:0] pm_byteena,
    input  logic [ADDR_W-1:0]   pm_wraddr,
    input  logic [PM_DW-1:0]    pm_wdata,
    input  logic [ADDR_W-1:0]   pm_rdaddr,
    output logic [PM_DW-1:0]    pm_q
);

    localparam int unsigned DEPTH  = 1 << ADDR_W;
    localparam int unsigned LANE_W = PM_DW / PM_LANES;

    logic [IM_DW-1:0] im_mem [DEPTH];
    logic [PM_DW-1:0] pm_mem [DEPTH];
    logic [IM_DW-1:0] im_q_r;
    logic [PM_DW-1:0] pm_q_r;

    // Instruction RAM write port. Writes proceed during reset.
    always_ff @(posedge clk) begin
        if (im_wren) begin
            im_mem[im_wraddr] <= im_wdata;
        end
    end

    // Registering the read data (not the address) gives old-data read-during-write.
    always_ff @(posedge clk) begin
        if (reset) begin
            im_q_r <= '0;
        end else begin
            im_q_r <= im_mem[im_rdaddr];
        end
    end

    // Predictor RAM write port with per-lane enables; disabled lanes hold their value.
    always_ff @(posedge clk) begin
        if (pm_wren) begin
            for (int k = 0; k < PM_LANES; k++) begin
                if (pm_byteena[k]) begin
                    pm_mem[pm_wraddr][k*LANE_W +: LANE_W] <= pm_wdata[k*LANE_W +: LANE_W];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pm_q_r <= '0;
        end else begin
            pm_q_r <= pm_mem[pm_rdaddr];
        end
    end

    assign im_q = im_q_r;
    assign pm_q = pm_q_r;

endmodule

// File: tb/tb_bpred_dual_mem.sv
// Scoreboard bench for bpred_dual_mem: a reference model predicts each cycle's q outputs,
// a negedge monitor compares them, and directed checks pin the key scenarios to constants.
module tb_bpred_dual_mem;

    logic        clk = 1'b0;
    logic        reset;
    logic        im_wren;
    logic [7:0]  im_wraddr;
    logic [31:0] im_wdata;
    logic [7:0]  im_rdaddr;
    logic [31:0] im_q;
    logic        pm_wren;
    logic [3:0]  pm_byteena;
    logic [7:0]  pm_wraddr;
    logic [35:0] pm_wdata;
    logic [7:0]  pm_rdaddr;
    logic [35:0] pm_q;

    int checks = 0;
    int errors = 0;

    logic [31:0] im_model [256];
    logic [35:0] pm_model [256];
    logic [31:0] exp_im_q [$];
    logic [35:0] exp_pm_q [$];

    bpred_dual_mem dut (
        .clk        (clk),
        .reset      (reset),
        .im_wren    (im_wren),
        .im_wraddr  (im_wraddr),
        .im_wdata   (im_wdata),
        .im_rdaddr  (im_rdaddr),
        .im_q       (im_q),
        .pm_wren    (pm_wren),
        .pm_byteena (pm_byteena),
        .pm_wraddr  (pm_wraddr),
        .pm_wdata   (pm_wdata),
        .pm_rdaddr  (pm_rdaddr),
        .pm_q       (pm_q)
    );

    always #5 clk = ~clk;

    // One clock of stimulus. Expected q is taken from the model before this cycle's writes.
    task automatic step(input logic rst,
                        input logic im_w, input logic [7:0] im_wa, input logic [31:0] im_wd,
                        input logic [7:0] im_ra,
                        input logic pm_w, input logic [3:0] be, input logic [7:0] pm_wa,
                        input logic [35:0] pm_wd, input logic [7:0] pm_ra);
        logic [35:0] mask;
        reset      = rst;
        im_wren    = im_w;
        im_wraddr  = im_wa;
        im_wdata   = im_wd;
        im_rdaddr  = im_ra;
        pm_wren    = pm_w;
        pm_byteena = be;
        pm_wraddr  = pm_wa;
        pm_wdata   = pm_wd;
        pm_rdaddr  = pm_ra;
        exp_im_q.push_back(rst ? 32'h0 : im_model[im_ra]);
        exp_pm_q.push_back(rst ? 36'h0 : pm_model[pm_ra]);
        if (im_w) im_model[im_wa] = im_wd;
        mask = 36'h0;
        for (int k = 0; k < 4; k++) begin
            if (be[k]) mask = mask | (36'h1FF << (9 * k));
        end
        if (pm_w) pm_model[pm_wa] = (pm_model[pm_wa] & ~mask) | (pm_wd & mask);
        @(posedge clk);
        #1;
    endtask

    task automatic read(input logic [7:0] im_ra, input logic [7:0] pm_ra);
        step(1'b0, 1'b0, 8'h0, 32'h0, im_ra, 1'b0, 4'h0, 8'h0, 36'h0, pm_ra);
    endtask

    task automatic check_im(input string name, input logic [31:0] exp);
        checks++;
        if (im_q !== exp) begin
            errors++;
            $display("FAIL %s: im_q got %h expected %h", name, im_q, exp);
        end
    endtask

    task automatic check_pm(input string name, input logic [35:0] exp);
        checks++;
        if (pm_q !== exp) begin
            errors++;
            $display("FAIL %s: pm_q got %h expected %h", name, pm_q, exp);
        end
    endtask

    // Monitor: outputs are always valid, so every cycle's prediction is compared.
    always @(negedge clk) begin
        if (exp_im_q.size() > 0 && exp_pm_q.size() > 0) begin
            logic [31:0] ei;
            logic [35:0] ep;
            ei = exp_im_q.pop_front();
            ep = exp_pm_q.pop_front();
            checks += 2;
            if (im_q !== ei) begin
                errors++;
                $display("FAIL sb_im_q: got %h expected %h", im_q, ei);
            end
            if (pm_q !== ep) begin
                errors++;
                $display("FAIL sb_pm_q: got %h expected %h", pm_q, ep);
            end
        end
    end

    initial begin
        int budget;
        for (int i = 0; i < 256; i++) begin
            im_model[i] = 32'h0;
            pm_model[i] = 36'h0;
        end

        // Clear both RAMs by sweeping writes during reset.
        for (int i = 0; i < 256; i++) begin
            step(1'b1, 1'b1, 8'(i), 32'h0, 8'h0, 1'b1, 4'hF, 8'(i), 36'h0, 8'h0);
        end
        check_im("reset_im_q", 32'h0);
        check_pm("reset_pm_q", 36'h0);

        // Instruction memory basic access.
        step(1'b0, 1'b1, 8'h05, 32'hDEADBEEF, 8'h00, 1'b0, 4'h0, 8'h0, 36'h0, 8'h0);
        step(1'b0, 1'b1, 8'hFF, 32'h12345678, 8'h00, 1'b0, 4'h0, 8'h0, 36'h0, 8'h0);
        read(8'h05, 8'h00);
        check_im("im_read_05", 32'hDEADBEEF);
        read(8'hFF, 8'h00);
        check_im("im_read_ff", 32'h12345678);

        // Predictor lane enables.
        step(1'b0, 1'b0, 8'h0, 32'h0, 8'h0, 1'b1, 4'b1111, 8'h10, 36'hABCDEF012, 8'h00);
        step(1'b0, 1'b0, 8'h0, 32'h0, 8'h0, 1'b1, 4'b0001, 8'h10, 36'h000000155, 8'h00);
        read(8'h00, 8'h10);
        check_pm("pm_lane0_only", 36'hABCDEF155);
        step(1'b0, 1'b0, 8'h0, 32'h0, 8'h0, 1'b1, 4'b1000, 8'h10, 36'hFFFFFFFFF, 8'h00);
        read(8'h00, 8'h10);
        check_pm("pm_lane3_only", 36'hFFCDEF155);
        step(1'b0, 1'b0, 8'h0, 32'h0, 8'h0, 1'b1, 4'b0000, 8'h10, 36'h000000000, 8'h00);
        read(8'h00, 8'h10);
        check_pm("pm_no_lanes", 36'hFFCDEF155);

        // Read-during-write returns old data on both RAMs.
        step(1'b0, 1'b1, 8'h20, 32'h11111111, 8'h20, 1'b1, 4'hF, 8'h20, 36'h123456789, 8'h20);
        check_im("im_rdw_old", 32'h0);
        check_pm("pm_rdw_old", 36'h0);
        read(8'h20, 8'h20);
        check_im("im_rdw_new", 32'h11111111);
        check_pm("pm_rdw_new", 36'h123456789);

        // Reset: q forced to 0, writes still land, memory otherwise preserved.
        step(1'b0, 1'b1, 8'h30, 32'hCAFEF00D, 8'h30, 1'b1, 4'hF, 8'h00, 36'hAAAAAAAAA, 8'h00);
        step(1'b0, 1'b0, 8'h0, 32'h0, 8'h30, 1'b1, 4'hF, 8'h01, 36'hBBBBBBBBB, 8'h00);
        step(1'b0, 1'b0, 8'h0, 32'h0, 8'h30, 1'b1, 4'hF, 8'h02, 36'hCCCCCCCCC, 8'h00);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 8'h0, 32'h0, 8'h30, 1'b1, 4'hF, 8'(i), 36'h0, 8'(i));
            check_im("rst_im_q_zero", 32'h0);
            check_pm("rst_pm_q_zero", 36'h0);
        end
        for (int i = 0; i < 3; i++) begin
            read(8'h30, 8'(i));
            check_pm("rst_pm_cleared", 36'h0);
            check_im("rst_im_kept", 32'hCAFEF00D);
        end

        // Concurrent writes to the same index of each RAM.
        step(1'b0, 1'b1, 8'h40, 32'h55AA55AA, 8'h00, 1'b1, 4'hF, 8'h40, 36'h0F0F0F0F0, 8'h00);
        read(8'h40, 8'h40);
        check_im("indep_im", 32'h55AA55AA);
        check_pm("indep_pm", 36'h0F0F0F0F0);

        // Randomized traffic; small address range to provoke collisions.
        for (int n = 0; n < 3000; n++) begin
            logic [7:0] a0, a1, a2, a3;
            a0 = 8'($urandom_range(0, 15));
            a1 = 8'($urandom_range(0, 15));
            a2 = (n % 4 == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
            a3 = 8'($urandom_range(0, 15));
            step(($urandom_range(0, 49) == 0), 1'($urandom), a0, $urandom, a1,
                 1'($urandom), 4'($urandom), a2, {4'($urandom), 32'($urandom)}, a3);
        end
        read(8'h00, 8'h00);

        budget = 20;
        while ((exp_im_q.size() > 0 || exp_pm_q.size() > 0) && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        if (exp_im_q.size() > 0 || exp_pm_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", exp_im_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
